// File: rtl/dct2d_pkg.sv
// Shared types and constants for the 2D DCT sequencer and its datapath.
package dct2d_pkg;

    // Sequencer phases: load rows, wait for writes to land, read columns.
    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDrain,
        StRead
    } state_e;

    localparam int unsigned N_DEF          = 8;
    localparam int unsigned ROW_LAT_DEF    = 1;
    localparam int unsigned MEM_RD_LAT_DEF = 1;
    localparam int unsigned COL_LAT_DEF    = 1;

    // Index width for an N-entry block; a 1-row block still needs one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IDX_W = idx_w(N_DEF);

endpackage

// File: rtl/dct2d_seq_ctrl_if.sv
// Handshake, transpose-memory and output-flag bundle of the DCT sequencer.
interface dct2d_seq_ctrl_if #(
    parameter int unsigned N = dct2d_pkg::N_DEF
);
    import dct2d_pkg::*;

    localparam int unsigned IW = idx_w(N);

    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic          mem_wr_en;
    logic [IW-1:0] mem_wr_addr;
    logic          mem_rd_en;
    logic [IW-1:0] mem_rd_addr;
    logic          col_sel;
    logic          out_valid;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          busy;

    // Sequencer side.
    modport master (
        input  abort, in_valid,
        output in_ready, mem_wr_en, mem_wr_addr, mem_rd_en, mem_rd_addr,
        output col_sel, out_valid, out_idx, out_last, busy
    );

    // Upstream source / datapath side.
    modport slave (
        output abort, in_valid,
        input  in_ready, mem_wr_en, mem_wr_addr, mem_rd_en, mem_rd_addr,
        input  col_sel, out_valid, out_idx, out_last, busy
    );

endinterface

// File: rtl/dly_line.sv
// Fixed-depth delay line. The MSB of each word is its valid flag, which feeds o_busy.
module dly_line #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic [Width-1:0] i_data,
    output logic [Width-1:0] o_data,
    output logic             o_busy
);

    if (Depth == 0) begin : g_pass
        // No storage: the line is always empty and clk/reset/clear are irrelevant.
        logic w_unused;
        assign w_unused = i_clk ^ i_rst_n ^ i_clr;
        assign o_data   = i_data;
        assign o_busy   = 1'b0;
    end else begin : g_pipe
        logic [Width-1:0] r_stage [Depth];

        // Shift one stage per cycle; a clear empties the whole line.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int i = 0; i < int'(Depth); i++) r_stage[i] <= '0;
            end else if (i_clr) begin
                for (int i = 0; i < int'(Depth); i++) r_stage[i] <= '0;
            end else begin
                r_stage[0] <= i_data;
                for (int i = 1; i < int'(Depth); i++) r_stage[i] <= r_stage[i-1];
            end
        end

        // Non-empty while any stage still carries a valid word.
        always_comb begin
            o_busy = 1'b0;
            for (int i = 0; i < int'(Depth); i++) o_busy = o_busy | r_stage[i][Width-1];
        end

        assign o_data = r_stage[Depth-1];
    end

endmodule

// File: rtl/dct2d_seq_ctrl.sv
// Two-pass 8x8 DCT sequencer: row loads into transpose memory, column reads, output flags.
module dct2d_seq_ctrl
    import dct2d_pkg::*;
#(
    parameter int unsigned N          = N_DEF,
    parameter int unsigned ROW_LAT    = ROW_LAT_DEF,
    parameter int unsigned MEM_RD_LAT = MEM_RD_LAT_DEF,
    parameter int unsigned COL_LAT    = COL_LAT_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    dct2d_seq_ctrl_if.master       io_bus
);

    localparam int unsigned   IW       = idx_w(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_e        r_state;
    logic [IW-1:0] r_wr_cnt;
    logic [IW-1:0] r_rd_addr;
    logic          r_in_ready;
    logic          r_rd_en;

    logic          w_in_ready;
    logic          w_accept;
    logic [IW-1:0] w_wr_idx;
    logic [IW:0]   w_wr_q;
    logic          w_wr_busy;
    logic          w_col_sel;
    logic          w_rd_busy;
    logic [IW+1:0] w_out_q;
    logic          w_out_busy;

    // A row offered during abort must not be taken.
    assign w_in_ready = r_in_ready & ~io_bus.abort;
    assign w_accept   = io_bus.in_valid & w_in_ready;
    assign w_wr_idx   = w_accept ? r_wr_cnt : '0;

    // Block sequencer: counts accepts, waits for writes to land, then walks the columns.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_wr_cnt   <= '0;
            r_rd_addr  <= '0;
            r_in_ready <= 1'b1;
            r_rd_en    <= 1'b0;
        end else if (io_bus.abort) begin
            r_state    <= StIdle;
            r_wr_cnt   <= '0;
            r_rd_addr  <= '0;
            r_in_ready <= 1'b1;
            r_rd_en    <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StLoad: begin
                    if (w_accept) begin
                        if (r_wr_cnt == LAST_IDX) begin
                            r_wr_cnt   <= '0;
                            r_state    <= StDrain;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + 1'b1;
                            r_state  <= StLoad;
                        end
                    end
                end
                StDrain: begin
                    // Columns may only be read once the last row write has left the line.
                    if (!w_wr_busy) begin
                        r_state   <= StRead;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                    end
                end
                StRead: begin
                    if (r_rd_addr == LAST_IDX) begin
                        r_state    <= StIdle;
                        r_rd_en    <= 1'b0;
                        r_rd_addr  <= '0;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_rd_addr <= r_rd_addr + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    dly_line #(
        .Width (IW + 1),
        .Depth (ROW_LAT)
    ) u_wr_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (io_bus.abort),
        .i_data  ({w_accept, w_wr_idx}),
        .o_data  (w_wr_q),
        .o_busy  (w_wr_busy)
    );

    dly_line #(
        .Width (1),
        .Depth (MEM_RD_LAT)
    ) u_rd_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (io_bus.abort),
        .i_data  (r_rd_en),
        .o_data  (w_col_sel),
        .o_busy  (w_rd_busy)
    );

    dly_line #(
        .Width (IW + 2),
        .Depth (MEM_RD_LAT + COL_LAT)
    ) u_out_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (io_bus.abort),
        .i_data  ({r_rd_en, r_rd_addr, r_rd_en && (r_rd_addr == LAST_IDX)}),
        .o_data  (w_out_q),
        .o_busy  (w_out_busy)
    );

    assign io_bus.in_ready    = w_in_ready;
    assign io_bus.mem_wr_en   = w_wr_q[IW];
    assign io_bus.mem_wr_addr = w_wr_q[IW-1:0];
    assign io_bus.mem_rd_en   = r_rd_en;
    assign io_bus.mem_rd_addr = r_rd_addr;
    assign io_bus.col_sel     = w_col_sel;
    assign io_bus.out_valid   = w_out_q[IW+1];
    assign io_bus.out_idx     = w_out_q[IW:1];
    assign io_bus.out_last    = w_out_q[0];
    assign io_bus.busy        = (r_state != StIdle) | w_wr_busy | w_rd_busy | w_out_busy;

endmodule

// File: doc/dct2d_seq_ctrl.md
Name: dct2d_seq_ctrl

Overview:
Sequencer for the two-pass 8x8 2D DCT: row DCT, transpose block memory, then column DCT. It accepts eight input rows over a valid/ready handshake and times the transpose-memory write strobes to the row-DCT latency. It then issues eight column reads, gates the column-DCT input mux and flags output rows valid/last. One block is in flight at a time; a new block is accepted only once the previous one has been read out of memory.

Parameters:
N, 8, rows/columns per block (power of two)
ROW_LAT, 1, cycles from row presented at row-DCT input to result at its output
MEM_RD_LAT, 1, cycles from mem_rd_en to read data valid at block memory output
COL_LAT, 1, cycles from column-DCT input to result at its output

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
abort  in  1  synchronous flush of current block
in_valid  in  1  upstream row valid
in_ready  out  1  controller accepts a row this cycle
mem_wr_en  out  1  write strobe to transpose memory
mem_wr_addr  out  $clog2(N)  row index being written
mem_rd_en  out  1  read strobe to transpose memory
mem_rd_addr  out  $clog2(N)  column index being read
col_sel  out  1  1 = column-DCT input takes memory data, 0 = forced zero
out_valid  out  1  column-DCT output row valid
out_idx  out  $clog2(N)  index of the current output row
out_last  out  1  final output row of the block
busy  out  1  state != IDLE or any delay line non-empty

Behaviour:
- Reset, asserted asynchronously: state=IDLE, all counters 0, all delay lines cleared. Every output is 0 except in_ready=1.
- States: IDLE, LOAD, DRAIN, READ.
- A row is accepted when in_valid && in_ready.
- IDLE: in_ready=1. An accepted row loads wr_cnt=1 and moves to LOAD; if N==1 it goes straight to DRAIN.
- LOAD: in_ready=1. Each accepted row increments wr_cnt. On the Nth accept, go to DRAIN with in_ready=0 from the next cycle. Gaps with in_valid=0 are allowed and hold state.
- Write timing: each accept pushes {1, row index} into a ROW_LAT-deep delay line. The delay-line output drives mem_wr_en and mem_wr_addr, so a row accepted at cycle t is written at t+ROW_LAT.
- DRAIN: in_ready=0. Wait until the write delay line is empty, i.e. the last write has been issued, then go to READ.
- READ: in_ready=0. Assert mem_rd_en for exactly N consecutive cycles with mem_rd_addr = 0..N-1. After the cycle with addr N-1, return to IDLE.
- Input pipelining: a row may be accepted in IDLE in the cycle after READ ends.
- col_sel: equals mem_rd_en delayed MEM_RD_LAT cycles. At all other times it is 0, so the column DCT receives zeros.
- Output flags: out_valid, out_idx and out_last equal {mem_rd_en, mem_rd_addr, addr==N-1} delayed MEM_RD_LAT+COL_LAT cycles.
- Total latency from the first accept to the first out_valid, with no input gaps: N + ROW_LAT + 1 + MEM_RD_LAT + COL_LAT cycles. With defaults that is 12.
- abort: highest priority after reset. Next cycle: state=IDLE, counters 0, all delay lines cleared, out_valid=0. A row presented in the abort cycle is not accepted (in_ready forced 0 that cycle).
- Reset deasserting mid-block: the controller starts clean in IDLE. No partial block is completed.
- Counters are $clog2(N) bits and wrap naturally. No counter exceeds N-1.
- No output backpressure: downstream must take every out_valid row.

Decomposition:
- Package dct2d_pkg holds:
  - state enum {IDLE, LOAD, DRAIN, READ}
  - N-derived index width constant
  - default latency constants shared with the datapath top
- Sub-module dly_line: parameterised width and depth, async active-low reset, depth 0 is a pass-through. It is instantiated three times: write timing, read-data timing and output flags.

Test Plan:
- Back-to-back load, defaults: in_valid=1 continuously, rows accepted at cycles 0-7.
  - mem_wr_en high in cycles 1-8, addresses 0-7.
  - mem_rd_en high in cycles 10-17, addresses 0-7.
  - out_valid high in cycles 12-19; out_last=1 only at cycle 19.
  - in_ready=0 during cycles 8-17 and back to 1 at cycle 18.
- Gapped input: in_valid asserted only on even cycles. Exactly 8 accepts with write addresses 0-7 in order; READ entered only after the write at addr 7; out_idx sequence 0-7.
- Latency sweep: ROW_LAT=3, MEM_RD_LAT=2, COL_LAT=4 with back-to-back input. First out_valid at cycle 8+3+1+2+4=18 after the first accept.
- Abort: assert abort in cycle 12 of the first scenario. Next cycle: out_valid=0, mem_rd_en=0, in_ready=1, busy=0. A fresh block afterwards completes normally.
- Async reset: pull reset low at cycle 5 of LOAD, between clock edges. All outputs clear immediately and in_ready=1. After release, a full block produces 8 out_valid rows.
- Two consecutive blocks: in_valid held high across both. The second block's first accept occurs at cycle 18, and its out_valid rows start at cycle 30.
